// File: rtl/uart_rx_peer.sv
// uart_rx_peer: 8N1 UART receiver with a small pop FIFO and sticky framing/overrun flags.
module uart_rx_peer #(
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [15:0]                   div_i,
    input  logic                          rx_i,
    output logic [7:0]                    data_o,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic [$clog2(FIFO_DEPTH):0]   count_o,
    output logic                          busy_o,
    output logic                          frame_err_o,
    output logic                          overrun_o,
    input  logic                          clr_err_i
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

    state_t                 state, state_n;
    logic [SYNC_STAGES-1:0] sync;
    logic                   rxs, prev_rxs, fall;
    logic [15:0]            cnt, div_q;
    logic [2:0]             bit_idx;
    logic [7:0]             shreg;
    logic                   mid, last, push, ferr_set, pop, accept;
    logic [7:0]             mem [FIFO_DEPTH];
    logic [AW-1:0]          wptr, rptr;

    assign rxs    = sync[SYNC_STAGES-1];
    assign fall   = prev_rxs & ~rxs;
    assign mid    = cnt == {1'b0, div_q[15:1]};
    assign last   = cnt == div_q - 16'd1;
    assign busy_o = state != IDLE;

    always_comb begin
        state_n  = state;
        push     = 1'b0;
        ferr_set = 1'b0;
        case (state)
            IDLE:      state_n = fall ? START : IDLE;
            START:     state_n = mid ? (rxs ? IDLE : DATA) : START;
            DATA:      state_n = (last && bit_idx == 3'd7) ? STOP : DATA;
            STOP: begin
                state_n  = last ? (rxs ? IDLE : WAIT_HIGH) : STOP;
                push     = last & rxs;
                ferr_set = last & ~rxs;
            end
            WAIT_HIGH: state_n = rxs ? IDLE : WAIT_HIGH;
            default:   state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync     <= '1;
            prev_rxs <= 1'b1;
            state    <= IDLE;
            cnt      <= '0;
            div_q    <= 16'd4;
            bit_idx  <= '0;
            shreg    <= '0;
        end else begin
            sync     <= {sync[SYNC_STAGES-2:0], rx_i};
            prev_rxs <= rxs;
            state    <= state_n;
            if (state == IDLE) begin
                cnt <= '0;
                if (fall)
                    div_q <= (div_i < 16'd4) ? 16'd4 : div_i;
            end else begin
                // every sample point restarts the bit timer
                cnt <= ((state == START && mid) || ((state == DATA || state == STOP) && last)) ? 16'd0 : cnt + 16'd1;
            end
            if (state == START && mid)
                bit_idx <= '0;
            if (state == DATA && last) begin
                shreg[bit_idx] <= rxs;
                bit_idx        <= bit_idx + 3'd1;
            end
        end
    end

    assign valid_o = count_o != '0;
    assign pop     = valid_o & ready_i;
    assign accept  = push & ((count_o != CW'(FIFO_DEPTH)) | pop);
    assign data_o  = mem[rptr];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < FIFO_DEPTH; i++)
                mem[i] <= '0;
            wptr        <= '0;
            rptr        <= '0;
            count_o     <= '0;
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;
        end else begin
            if (accept) begin
                mem[wptr] <= shreg;
                wptr      <= wptr + AW'(1);
            end
            if (pop)
                rptr <= rptr + AW'(1);
            count_o <= count_o + CW'(accept) - CW'(pop);
            if (ferr_set)
                frame_err_o <= 1'b1;
            else if (clr_err_i)
                frame_err_o <= 1'b0;
            if (push && !accept)
                overrun_o <= 1'b1;
            else if (clr_err_i)
                overrun_o <= 1'b0;
        end
    end
endmodule

// File: tb/tb_uart_rx_peer.sv
// tb_uart_rx_peer: directed table-driven and sequence checks for uart_rx_peer.
module tb_uart_rx_peer;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [15:0] div_i = 16'd8;
    logic        rx_i = 1'b1;
    logic        ready_i = 1'b0;
    logic        clr_err_i = 1'b0;
    logic [7:0]  data_o;
    logic        valid_o, busy_o, frame_err_o, overrun_o;
    logic [2:0]  count_o;

    int errors = 0;
    int checks = 0;

    uart_rx_peer #(.FIFO_DEPTH(4), .SYNC_STAGES(2)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .div_i(div_i), .rx_i(rx_i),
        .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i), .count_o(count_o),
        .busy_o(busy_o), .frame_err_o(frame_err_o), .overrun_o(overrun_o),
        .clr_err_i(clr_err_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [15:0] div;
        int          cyc;
        logic [7:0]  tx;
        logic [7:0]  exp;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    // drives one 8N1 frame at cyc clocks per bit; optionally asserts ready_i for the final stop-bit cycle
    task automatic send(input logic [7:0] b, input logic stop, input int cyc, input logic pop_last);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx_i = f[i];
            for (int j = 0; j < cyc; j++) begin
                if (pop_last && i == 9 && j == cyc - 1)
                    ready_i = 1'b1;
                @(posedge clk_i);
                #1;
            end
        end
        ready_i = 1'b0;
    endtask

    task automatic pop_expect(input string name, input logic [7:0] exp);
        check({name, "_valid"}, 32'(valid_o), 32'd1);
        check({name, "_data"}, 32'(data_o), 32'(exp));
        ready_i = 1'b1;
        idle(1);
        ready_i = 1'b0;
    endtask

    initial begin
        vecs[0] = '{16'd8,  8,  8'hA5, 8'hA5};
        vecs[1] = '{16'd8,  8,  8'h00, 8'h00};
        vecs[2] = '{16'd8,  8,  8'hFF, 8'hFF};
        vecs[3] = '{16'd5,  5,  8'h3C, 8'h3C};
        vecs[4] = '{16'd2,  4,  8'hC3, 8'hC3};
        vecs[5] = '{16'd0,  4,  8'h81, 8'h81};
        vecs[6] = '{16'd16, 16, 8'h6E, 8'h6E};

        idle(3);
        rst_i = 1'b0;
        idle(1);
        check("rst_count", 32'(count_o), 0);
        check("rst_valid", 32'(valid_o), 0);
        check("rst_data", 32'(data_o), 0);
        check("rst_busy", 32'(busy_o), 0);
        check("rst_ferr", 32'(frame_err_o), 0);
        check("rst_ovr", 32'(overrun_o), 0);

        foreach (vecs[k]) begin
            div_i = vecs[k].div;
            send(vecs[k].tx, 1'b1, vecs[k].cyc, 1'b0);
            idle(4);
            check($sformatf("vec%0d_count", k), 32'(count_o), 1);
            check($sformatf("vec%0d_busy", k), 32'(busy_o), 0);
            check($sformatf("vec%0d_ferr", k), 32'(frame_err_o), 0);
            check($sformatf("vec%0d_ovr", k), 32'(overrun_o), 0);
            pop_expect($sformatf("vec%0d", k), vecs[k].exp);
            check($sformatf("vec%0d_empty", k), 32'(valid_o), 0);
        end

        div_i = 16'd8;
        rx_i = 1'b0;
        idle(3);
        rx_i = 1'b1;
        idle(1);
        check("glitch_busy_mid", 32'(busy_o), 1);
        idle(10);
        check("glitch_busy", 32'(busy_o), 0);
        check("glitch_count", 32'(count_o), 0);
        check("glitch_ferr", 32'(frame_err_o), 0);

        send(8'h3C, 1'b0, 8, 1'b0);
        idle(160);
        check("brk_ferr", 32'(frame_err_o), 1);
        check("brk_count", 32'(count_o), 0);
        check("brk_busy", 32'(busy_o), 1);
        rx_i = 1'b1;
        idle(6);
        check("brk_release_busy", 32'(busy_o), 0);
        send(8'h11, 1'b1, 8, 1'b0);
        idle(2);
        check("brk_after_count", 32'(count_o), 1);
        check("brk_ferr_sticky", 32'(frame_err_o), 1);
        pop_expect("brk_after", 8'h11);
        clr_err_i = 1'b1;
        idle(1);
        clr_err_i = 1'b0;
        check("ferr_clr", 32'(frame_err_o), 0);

        for (int b = 1; b <= 5; b++) begin
            send(8'(b), 1'b1, 8, 1'b0);
            idle(2);
        end
        check("ovr_count", 32'(count_o), 4);
        check("ovr_flag", 32'(overrun_o), 1);
        for (int b = 1; b <= 4; b++)
            pop_expect($sformatf("ovr_pop%0d", b), 8'(b));
        check("ovr_drained", 32'(valid_o), 0);

        clr_err_i = 1'b1;
        idle(1);
        clr_err_i = 1'b0;
        check("ovr_clr", 32'(overrun_o), 0);
        for (int b = 1; b <= 4; b++) begin
            send(8'h20 + 8'(b), 1'b1, 8, 1'b0);
            idle(2);
        end
        check("full_count", 32'(count_o), 4);
        send(8'h25, 1'b1, 8, 1'b1);
        idle(1);
        check("pp_ovr", 32'(overrun_o), 0);
        check("pp_count", 32'(count_o), 4);
        for (int b = 2; b <= 5; b++)
            pop_expect($sformatf("pp_pop%0d", b), 8'h20 + 8'(b));
        check("pp_drained", 32'(count_o), 0);

        send(8'h77, 1'b1, 8, 1'b0);
        idle(2);
        send(8'h33, 1'b0, 8, 1'b0);
        rx_i = 1'b1;
        idle(4);
        rx_i = 1'b0;
        idle(8);
        rx_i = 1'b1;
        idle(35);
        check("mid_busy", 32'(busy_o), 1);
        check("mid_ferr", 32'(frame_err_o), 1);
        rst_i = 1'b1;
        idle(1);
        rst_i = 1'b0;
        check("mrst_count", 32'(count_o), 0);
        check("mrst_valid", 32'(valid_o), 0);
        check("mrst_data", 32'(data_o), 0);
        check("mrst_busy", 32'(busy_o), 0);
        check("mrst_ferr", 32'(frame_err_o), 0);
        idle(40);
        check("mrst_nostart", 32'(busy_o), 0);
        send(8'h5A, 1'b1, 8, 1'b0);
        idle(2);
        check("mrst_rx_count", 32'(count_o), 1);
        check("mrst_rx_data", 32'(data_o), 32'h5A);
        for (int b = 0; b < 4; b++) begin
            send(8'hC0 + 8'(b), 1'b1, 8, 1'b0);
            idle(2);
        end
        check("mrst_ovr", 32'(overrun_o), 1);
        clr_err_i = 1'b1;
        idle(1);
        clr_err_i = 1'b0;
        check("mrst_ovr_clr", 32'(overrun_o), 0);
        check("mrst_full", 32'(count_o), 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
